// File: rtl/bpred_counter_table.sv
// Branch-prediction table of saturating counters with registered predict ports,
// a 2-stage read-modify-write update pipeline, optional gshare indexing and a self-init sweep.
module bpred_counter_table #(
    parameter int unsigned DPT    = 64,
    parameter int unsigned CNTW   = 2,
    parameter int unsigned RSTVAL = 2 ** (CNTW - 1),
    parameter int unsigned NRP    = 2,
    parameter int unsigned GHW    = 0,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned ADW   = $clog2(DPT),
    localparam int unsigned GHRW  = (GHW > 0) ? GHW : 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i_init,
    output logic                 o_busy,
    input  logic [NRP-1:0]       i_rden,
    input  logic [NRP*ADW-1:0]   i_raddr,
    output logic [NRP*CNTW-1:0]  o_rdata,
    output logic [NRP-1:0]       o_ptaken,
    input  logic                 i_upd_en,
    input  logic [ADW-1:0]       i_upd_addr,
    input  logic [GHRW-1:0]      i_upd_ghr,
    input  logic                 i_upd_taken,
    output logic [GHRW-1:0]      o_ghr
);

    localparam logic [CNTW-1:0] RST_C   = CNTW'(RSTVAL);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [ADW-1:0]  GMASK   = (GHW > 0) ? {ADW{1'b1}} : {ADW{1'b0}};
    localparam logic [ADW-1:0]  LAST_IX = ADW'(DPT - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                      state_q, state_d;
    logic                        busy_q;
    logic [ADW-1:0]              cnt_q, cnt_d;
    logic [GHRW-1:0]             ghr_q, ghr_d;
    logic                        u2_vld_q, u2_vld_d;
    logic [ADW-1:0]              u2_idx_q, u2_idx_d;
    logic [CNTW-1:0]             u2_old_q, u2_old_d;
    logic                        u2_tkn_q, u2_tkn_d;
    logic [NRP-1:0][CNTW-1:0]    rdata_q, rdata_d;
    logic [NRP-1:0][ADW-1:0]     rd_idx_c;
    logic [CNTW-1:0]             u2_new_c;
    logic [ADW-1:0]              upd_idx_c;
    logic                        busy_c;

    logic [CNTW-1:0]             mem [DPT];

    function automatic logic [CNTW-1:0] sat_step(input logic [CNTW-1:0] old, input logic taken);
        logic [CNTW-1:0] res;
        res = old;
        if (taken && old != CNT_MAX) begin
            res = old + CNTW'(1);
        end else if (!taken && old != '0) begin
            res = old - CNTW'(1);
        end
        return res;
    endfunction

    assign busy_c    = (state_q == S_INIT);
    assign u2_new_c  = sat_step(u2_old_q, u2_tkn_q);
    assign upd_idx_c = i_upd_addr ^ (ADW'(i_upd_ghr) & GMASK);

    // Sweep/run control and U1 stage; leaving RUN drops any update that would enter U2
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ghr_d    = ghr_q;
        u2_vld_d = 1'b0;
        u2_idx_d = u2_idx_q;
        u2_old_d = u2_old_q;
        u2_tkn_d = u2_tkn_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + ADW'(1);
                if (cnt_q == LAST_IX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_init) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    ghr_d   = '0;
                end else if (i_upd_en) begin
                    u2_vld_d = 1'b1;
                    u2_idx_d = upd_idx_c;
                    u2_tkn_d = i_upd_taken;
                    // Forward the in-flight result so back-to-back updates compound
                    u2_old_d = (u2_vld_q && u2_idx_q == upd_idx_c) ? u2_new_c : mem[upd_idx_c];
                    if (GHW > 0) begin
                        ghr_d = GHRW'({ghr_q, i_upd_taken});
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Predict read ports
    always_comb begin
        rdata_d  = rdata_q;
        rd_idx_c = '0;
        for (int p = 0; p < NRP; p++) begin
            rd_idx_c[p] = i_raddr[p*ADW +: ADW] ^ (ADW'(ghr_q) & GMASK);
            if (i_rden[p]) begin
                if (busy_c) begin
                    rdata_d[p] = RST_C;
                end else if (BYPASS != 0 && u2_vld_q && u2_idx_q == rd_idx_c[p]) begin
                    rdata_d[p] = u2_new_c;
                end else begin
                    rdata_d[p] = mem[rd_idx_c[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_INIT;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            ghr_q    <= '0;
            u2_vld_q <= 1'b0;
            u2_idx_q <= '0;
            u2_old_q <= '0;
            u2_tkn_q <= 1'b0;
            rdata_q  <= {NRP{RST_C}};
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d == S_INIT);
            cnt_q    <= cnt_d;
            ghr_q    <= ghr_d;
            u2_vld_q <= u2_vld_d;
            u2_idx_q <= u2_idx_d;
            u2_old_q <= u2_old_d;
            u2_tkn_q <= u2_tkn_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage has no reset; the sweep owns the write port while busy
    always_ff @(posedge clk) begin
        if (busy_c) begin
            mem[cnt_q] <= RST_C;
        end else if (u2_vld_q) begin
            mem[u2_idx_q] <= u2_new_c;
        end
    end

    always_comb begin
        o_ptaken = '0;
        for (int p = 0; p < NRP; p++) begin
            o_ptaken[p] = rdata_q[p][CNTW-1];
        end
    end

    assign o_rdata = rdata_q;
    assign o_busy  = busy_q;
    assign o_ghr   = ghr_q;

endmodule

// File: tb/tb_bpred_counter_table.sv
// Scoreboarded random + directed bench for bpred_counter_table (gshare, write-first config).
module tb_bpred_counter_table;

    localparam int DPT  = 64;
    localparam int CNTW = 2;
    localparam int NRP  = 2;
    localparam int GHW  = 4;
    localparam int ADW  = 6;

    logic                clk = 1'b0;
    logic                aresetn = 1'b0;
    logic                i_init = 1'b0;
    logic                o_busy;
    logic [NRP-1:0]      i_rden = '0;
    logic [NRP*ADW-1:0]  i_raddr = '0;
    logic [NRP*CNTW-1:0] o_rdata;
    logic [NRP-1:0]      o_ptaken;
    logic                i_upd_en = 1'b0;
    logic [ADW-1:0]      i_upd_addr = '0;
    logic [GHW-1:0]      i_upd_ghr = '0;
    logic                i_upd_taken = 1'b0;
    logic [GHW-1:0]      o_ghr;

    always #5 clk = ~clk;

    bpred_counter_table #(
        .DPT(DPT), .CNTW(CNTW), .RSTVAL(2), .NRP(NRP), .GHW(GHW), .BYPASS(1)
    ) dut (
        .clk(clk), .aresetn(aresetn), .i_init(i_init), .o_busy(o_busy),
        .i_rden(i_rden), .i_raddr(i_raddr), .o_rdata(o_rdata), .o_ptaken(o_ptaken),
        .i_upd_en(i_upd_en), .i_upd_addr(i_upd_addr), .i_upd_ghr(i_upd_ghr),
        .i_upd_taken(i_upd_taken), .o_ghr(o_ghr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counters as plain ints, history as an int, sweep as a countdown
    int mdl_mem [DPT];
    int mdl_ghr;
    int busy_left;
    int exp_q0 [$];
    int exp_q1 [$];
    logic [1:0] rd_pend = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_init();
        foreach (mdl_mem[i]) mdl_mem[i] = 2;
        mdl_ghr = 0;
    endfunction

    function automatic int mdl_read(input int ra);
        if (busy_left > 0) return 2;
        return mdl_mem[(ra ^ mdl_ghr) % DPT];
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) rd_pend <= '0;
        else          rd_pend <= i_rden;
    end

    task automatic mon_port(input int p);
        int e;
        bit have;
        have = 1'b0;
        e = 0;
        if (p == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        if (p == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL rd_underflow port %0d: got data with no expected entry", p);
        end else begin
            chk($sformatf("rdata_p%0d", p), 32'(o_rdata[p*CNTW +: CNTW]), 32'(e));
            chk($sformatf("ptaken_p%0d", p), 32'(o_ptaken[p]), 32'(e / 2));
        end
    endtask

    // Monitor: each port that was read last cycle presents data now
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend[0] === 1'b1) mon_port(0);
            if (rd_pend[1] === 1'b1) mon_port(1);
        end
    end

    task automatic step(input bit init, input bit ue, input int ua, input int ug, input bit ut,
                        input bit re0, input bit re1, input int ra0, input int ra1);
        int idx;
        @(negedge clk);
        chk("busy", 32'(o_busy), 32'(busy_left > 0));
        chk("ghr", 32'(o_ghr), 32'(mdl_ghr));
        i_init      = init;
        i_upd_en    = ue;
        i_upd_addr  = ADW'(ua);
        i_upd_ghr   = GHW'(ug);
        i_upd_taken = ut;
        i_rden      = {re1, re0};
        i_raddr     = {ADW'(ra1), ADW'(ra0)};
        if (re0) exp_q0.push_back(mdl_read(ra0));
        if (re1) exp_q1.push_back(mdl_read(ra1));
        if (busy_left > 0) begin
            busy_left--;
        end else if (init) begin
            mdl_init();
            busy_left = DPT;
        end else if (ue) begin
            idx = (ua ^ ug) % DPT;
            if (ut) mdl_mem[idx] = (mdl_mem[idx] < 3) ? mdl_mem[idx] + 1 : 3;
            else    mdl_mem[idx] = (mdl_mem[idx] > 0) ? mdl_mem[idx] - 1 : 0;
            mdl_ghr = ((mdl_ghr * 2) + int'(ut)) % 16;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int ua, input int ug, input bit ut);
        step(0, 1, ua, ug, ut, 0, 0, 0, 0);
    endtask

    // Read physical index on both ports (raddr pre-XORed with the current history)
    task automatic rd_idx(input int idx);
        step(0, 0, 0, 0, 0, 1, 1, idx ^ mdl_ghr, idx ^ mdl_ghr);
    endtask

    task automatic readout_all();
        for (int i = 0; i < DPT; i += 2) step(0, 0, 0, 0, 0, 1, 1, i ^ mdl_ghr, (i + 1) ^ mdl_ghr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        i_init = 1'b0; i_upd_en = 1'b0; i_rden = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(o_busy), 32'd1);
            chk("rst_rdata", 32'(o_rdata), 32'hA);
            chk("rst_ptaken", 32'(o_ptaken), 32'h3);
            chk("rst_ghr", 32'(o_ghr), 32'd0);
        end
        @(posedge clk);
        #2 aresetn = 1'b1;
        mdl_init();
        busy_left = DPT;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_init();
        busy_left = DPT;
        do_reset();
        idle(DPT + 1);
        readout_all();

        // Saturation at index 5
        for (int i = 0; i < 3; i++) upd(5, 0, 1);
        rd_idx(5);
        for (int i = 0; i < 4; i++) upd(5, 0, 0);
        rd_idx(5);
        for (int i = 0; i < 2; i++) upd(5, 0, 0);
        rd_idx(5);

        // Back-to-back updates to index 9, read during the second update's write cycle
        upd(9, 0, 1);
        upd(9, 0, 1);
        rd_idx(9);
        for (int i = 0; i < 3; i++) upd(9, 0, 0);
        rd_idx(9);
        idle(1);
        rd_idx(9);

        // Gshare: clear history, then taken,taken,not
        for (int i = 0; i < 4; i++) upd(40, 0, 0);
        upd(41, 0, 1);
        upd(41, 0, 1);
        upd(41, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 3, 5);
        chk("ghr_gshare", 32'(o_ghr), 32'd6);
        idle(1);

        // Flush: restart the sweep while an update to index 7 is in flight
        upd(7, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(DPT);
        rd_idx(7);
        idle(1);
        chk("ghr_flush", 32'(o_ghr), 32'd0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int ra0;
            int ra1;
            ra0 = int'($urandom_range(DPT - 1));
            ra1 = ($urandom_range(3) == 0) ? ra0 : int'($urandom_range(DPT - 1));
            step(($urandom_range(299) == 0), 1'($urandom), int'($urandom_range(DPT - 1)),
                 int'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom), ra0, ra1);
        end

        // Reset in the middle of a sweep
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(30);
        do_reset();
        idle(DPT + 1);
        readout_all();
        idle(3);

        chk("q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
